// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RISCV_MK1 instruction fetch stage.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned FIFO_CNT_W       = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  // Word aligned and inside the code RAM byte range [0, mem_words*4).
  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned mem_words);
    logic [32:0] w_limit;
    w_limit = 33'(mem_words) * 33'd4;
    return (pc[1:0] == 2'b00) && ({1'b0, pc} < w_limit);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry fetch queue; the head lives in a fixed register so decode sees registered outputs.
module fetch_skid_fifo
  import riscv_fetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  fetch_entry_t          i_push_entry,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output fetch_entry_t          o_head,
  output logic                  o_valid,
  output logic [FIFO_CNT_W-1:0] o_count
);

  fetch_entry_t r_entry0;
  fetch_entry_t r_entry1;
  logic         r_valid0;
  logic         r_valid1;

  fetch_entry_t w_next_entry0;
  fetch_entry_t w_next_entry1;
  logic         w_next_valid0;
  logic         w_next_valid1;

  // Pop shifts entry1 into the head, then a push lands in the first free slot.
  always_comb begin
    w_next_entry0 = r_entry0;
    w_next_entry1 = r_entry1;
    w_next_valid0 = r_valid0;
    w_next_valid1 = r_valid1;
    if (i_pop && r_valid0) begin
      w_next_entry0 = r_entry1;
      w_next_valid0 = r_valid1;
      w_next_valid1 = 1'b0;
    end
    if (i_push) begin
      if (!w_next_valid0) begin
        w_next_entry0 = i_push_entry;
        w_next_valid0 = 1'b1;
      end else begin
        w_next_entry1 = i_push_entry;
        w_next_valid1 = 1'b1;
      end
    end
    if (i_flush) begin
      w_next_valid0 = 1'b0;
      w_next_valid1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
    end else begin
      r_entry0 <= w_next_entry0;
      r_entry1 <= w_next_entry1;
      r_valid0 <= w_next_valid0;
      r_valid1 <= w_next_valid1;
    end
  end

  // The issue credit upstream must never let a push reach a full queue.
  always_ff @(posedge clk) begin
    if (!reset && !i_flush) begin
      assert (!(i_push && r_valid1))
        else $error("fetch_skid_fifo: push into full queue");
    end
  end

  assign o_head  = r_entry0;
  assign o_valid = r_valid0;
  assign o_count = {1'b0, r_valid0} + {1'b0, r_valid1};

endmodule

// File: rtl/riscv_fetch_unit.sv
// RISCV_MK1 fetch stage: PC, code RAM read issue, response capture and redirect/fault handling.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_WORDS = 40000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_address,
  output logic              imem_chipselect,
  output logic [3:0]        imem_byteenable,
  output logic              imem_write,
  output logic              imem_clken,
  input  logic [31:0]       imem_readdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic              if_fault
);

  logic [31:0] r_pc;
  logic        r_epoch;
  logic        r_halted;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_inflight_epoch;

  logic                  w_pc_ok;
  logic                  w_pop;
  logic                  w_credit;
  logic                  w_issue;
  logic                  w_resp_push;
  logic                  w_fault_push;
  logic                  w_push;
  fetch_entry_t          w_push_entry;
  fetch_entry_t          w_head;
  logic                  w_head_valid;
  logic [FIFO_CNT_W-1:0] w_count;

  assign w_pc_ok = pc_in_range(r_pc, MEM_WORDS);
  assign w_pop   = w_head_valid & if_ready;

  // Queued plus in-flight words, net of this cycle's pop, must leave room for one more.
  assign w_credit = ({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

  assign w_issue = !reset && !redirect_valid && !r_halted && w_pc_ok && w_credit;

  // A response from before the latest redirect carries a stale epoch and is dropped.
  assign w_resp_push = !reset && !redirect_valid && r_inflight && (r_inflight_epoch == r_epoch);

  // The fault entry waits until no read is outstanding and the queue has a free slot.
  assign w_fault_push = !reset && !redirect_valid && !r_halted && !w_pc_ok && !r_inflight
                        && (w_count < FIFO_CNT_W'(2));

  assign w_push = w_resp_push | w_fault_push;

  always_comb begin
    w_push_entry = '{pc: r_pc, instr: NOP_INSTR, fault: 1'b1};
    if (w_resp_push) begin
      w_push_entry = '{pc: r_inflight_pc, instr: imem_readdata, fault: 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc             <= RESET_PC;
      r_epoch          <= 1'b0;
      r_halted         <= 1'b0;
      r_inflight       <= 1'b0;
      r_inflight_pc    <= '0;
      r_inflight_epoch <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc    <= r_pc;
        r_inflight_epoch <= r_epoch;
      end
      if (redirect_valid) begin
        r_pc     <= redirect_pc;
        r_epoch  <= ~r_epoch;
        r_halted <= 1'b0;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_fault_push) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  fetch_skid_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_head       (w_head),
    .o_valid      (w_head_valid),
    .o_count      (w_count)
  );

  assign imem_address    = r_pc[ADDR_W+1:2];
  assign imem_chipselect = w_issue;
  assign imem_byteenable = 4'hF;
  assign imem_write      = 1'b0;
  assign imem_clken      = 1'b1;

  assign if_valid = w_head_valid;
  assign if_instr = w_head.instr;
  assign if_pc    = w_head.pc;
  assign if_fault = w_head.fault;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: directed scenarios plus randomized redirects/backpressure against a stream model.
module tb_riscv_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned MEM_WORDS = 40000;
  localparam logic [31:0] RST_PC    = 32'h0000_0000;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

  logic              clk;
  logic              reset;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_address;
  logic              imem_chipselect;
  logic [3:0]        imem_byteenable;
  logic              imem_write;
  logic              imem_clken;
  logic [31:0]       imem_readdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_instr;
  logic [31:0]       if_pc;
  logic              if_fault;

  int          checks = 0;
  int          errors = 0;
  int          pops   = 0;
  logic [31:0] salt;
  logic [31:0] exp_pc;
  logic        exp_done;
  logic [31:0] last_pc;
  logic        last_fault;

  riscv_fetch_unit #(
    .RESET_PC  (RST_PC),
    .ADDR_W    (ADDR_W),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_address    (imem_address),
    .imem_chipselect (imem_chipselect),
    .imem_byteenable (imem_byteenable),
    .imem_write      (imem_write),
    .imem_clken      (imem_clken),
    .imem_readdata   (imem_readdata),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_fault        (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ salt;
  endfunction

  function automatic logic addr_ok(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc < MEM_BYTES);
  endfunction

  // Code RAM: one-cycle read latency; garbage on the bus when not selected.
  always @(posedge clk) begin
    if (imem_chipselect) imem_readdata <= mem_word(32'(imem_address));
    else                 imem_readdata <= $urandom();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
  endtask

  // Stream model: after reset/redirect to X, decode sees X, X+4, ... until the first
  // bad PC, which appears once as a NOP fault entry, then nothing.
  task automatic sample();
    logic ok;
    @(negedge clk);
    if (reset) begin
      exp_pc   = RST_PC;
      exp_done = 1'b0;
    end else begin
      if (imem_chipselect) check("cs_addr_in_range", 32'(imem_address < ADDR_W'(MEM_WORDS)), 32'd1);
      if (if_valid && if_ready) begin
        last_pc    = if_pc;
        last_fault = if_fault;
        pops++;
        if (exp_done) begin
          check("entry_after_fault", 32'(if_valid), 32'd0);
        end else begin
          ok = addr_ok(exp_pc);
          check("pop_pc", if_pc, exp_pc);
          check("pop_instr", if_instr, ok ? mem_word(exp_pc >> 2) : NOP_INSTR);
          check("pop_fault", 32'(if_fault), 32'(!ok));
          if (ok) exp_pc = exp_pc + 32'd4;
          else    exp_done = 1'b1;
        end
      end
      if (redirect_valid) begin
        exp_pc   = redirect_pc;
        exp_done = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  initial begin
    int base_pops;
    salt           = $urandom() | 32'h8000_0000;
    exp_pc         = RST_PC;
    exp_done       = 1'b0;
    last_pc        = '0;
    last_fault     = 1'b0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;

    // Reset state
    tick();
    tick();
    sample();
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_chipselect", 32'(imem_chipselect), 32'd0);
    check("rst_if_fault", 32'(if_fault), 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("const_byteenable", 32'(imem_byteenable), 32'hF);
    check("const_write", 32'(imem_write), 32'd0);
    check("const_clken", 32'(imem_clken), 32'd1);
    tick();
    reset = 1'b0;

    // Streaming from RESET_PC: issue on consecutive cycles, valid two cycles after first issue
    for (int k = 0; k < 6; k++) begin
      sample();
      check("seq_chipselect", 32'(imem_chipselect), 32'd1);
      check("seq_address", 32'(imem_address), 32'(k));
      check("seq_if_valid", 32'(if_valid), 32'(k >= 2));
      if (k >= 2) begin
        check("seq_if_pc", if_pc, 32'((k - 2) * 4));
        check("seq_if_instr", if_instr, mem_word(32'(k - 2)));
      end
      tick();
    end

    // Backpressure: head holds, issue stops
    if_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      sample();
      check("bp_chipselect", 32'(imem_chipselect), 32'd0);
      check("bp_if_valid", 32'(if_valid), 32'd1);
      check("bp_head_pc", if_pc, exp_pc);
      tick();
    end
    if_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      sample();
      check("release_no_gap", 32'(if_valid), 32'd1);
      tick();
    end

    // Redirect with a read in flight
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    sample();
    check("redir_t1_if_valid", 32'(if_valid), 32'd0);
    check("redir_t1_chipselect", 32'(imem_chipselect), 32'd1);
    check("redir_t1_address", 32'(imem_address), 32'h40);
    tick();
    sample();
    check("redir_t2_if_valid", 32'(if_valid), 32'd0);
    tick();
    sample();
    check("redir_t3_if_valid", 32'(if_valid), 32'd1);
    check("redir_t3_if_pc", if_pc, 32'h0000_0100);
    tick();
    for (int i = 0; i < 4; i++) cycle();

    // Misaligned redirect: one fault entry, no reads
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    cycle();
    redirect_valid = 1'b0;
    sample();
    check("mis_t1_chipselect", 32'(imem_chipselect), 32'd0);
    check("mis_t1_if_valid", 32'(if_valid), 32'd0);
    tick();
    sample();
    check("mis_if_valid", 32'(if_valid), 32'd1);
    check("mis_if_pc", if_pc, 32'h0000_0102);
    check("mis_if_instr", if_instr, 32'h0000_0013);
    check("mis_if_fault", 32'(if_fault), 32'd1);
    check("mis_chipselect", 32'(imem_chipselect), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      sample();
      check("halt_if_valid", 32'(if_valid), 32'd0);
      check("halt_chipselect", 32'(imem_chipselect), 32'd0);
      tick();
    end

    // Run off the end of the code RAM
    base_pops      = pops;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0002_70F0;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    sample();
    check("end_pop_count", 32'(pops - base_pops), 32'd5);
    check("end_last_pc", last_pc, 32'h0002_7100);
    check("end_last_fault", 32'(last_fault), 32'd1);
    check("end_if_valid", 32'(if_valid), 32'd0);
    check("end_chipselect", 32'(imem_chipselect), 32'd0);
    tick();

    // Reset mid-stream with a read in flight
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    sample();
    check("mrst_if_valid", 32'(if_valid), 32'd0);
    check("mrst_chipselect", 32'(imem_chipselect), 32'd1);
    check("mrst_address", 32'(imem_address), RST_PC >> 2);
    tick();
    cycle();
    sample();
    check("mrst_restart_valid", 32'(if_valid), 32'd1);
    check("mrst_restart_pc", if_pc, RST_PC);
    check("mrst_restart_instr", if_instr, mem_word(RST_PC >> 2));
    tick();

    // Randomized backpressure and redirects
    base_pops = pops;
    for (int i = 0; i < 400; i++) begin
      if_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 4);
      if (redirect_valid) begin
        case ($urandom_range(0, 9))
          7:       redirect_pc = (32'($urandom_range(0, MEM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
          8:       redirect_pc = MEM_BYTES - 32'(4 * $urandom_range(1, 6));
          9:       redirect_pc = $urandom();
          default: redirect_pc = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
        endcase
      end
      cycle();
    end
    redirect_valid = 1'b0;
    sample();
    check("rand_progress", 32'(pops - base_pops > 50), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
